// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// register-address width and the bubble instruction loaded on a flush.
package pipe_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StErr     = 2'b10
  } state_e;

  localparam int unsigned REG_AW = 5;

  // sll r0, r0, 0 -- what a flushed pipeline register holds
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones; updates on the falling edge like the
// pipeline registers it sits beside.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipe: load-use bubbles, taken-branch
// squash, data-memory wait freeze with timeout, plus saturating event counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW      = pipe_pkg::REG_AW,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic              ID_UsesRt,
  input  logic [REG_AW-1:0] EX_Rd,
  input  logic              EX_MemRd,
  input  logic              EX_RegWr,
  input  logic              EX_BrTaken,
  input  logic              MEM_Req,
  input  logic              DMemAck,
  output logic              PCWr,
  output logic              IFIDWr,
  output logic              IDEXWr,
  output logic              EXMEMWr,
  output logic              MEMWBWr,
  output logic              IFIDFlush,
  output logic              IDEXFlush,
  output logic              MEMWBBubble,
  output logic              Err,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt,
  output logic [CNT_W-1:0]  WaitCnt
);

  import pipe_pkg::*;

  localparam int unsigned TmrW = $clog2(MEM_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [TmrW-1:0] tmr_inc;
  logic            memblk;
  logic            load_use;
  logic            live;
  logic            wait_ev, flush_ev, stall_ev;

  assign memblk   = MEM_Req & ~DMemAck;
  assign load_use = EX_MemRd & EX_RegWr & (EX_Rd != '0) &
                    ((EX_Rd == ID_Rs) | (ID_UsesRt & (EX_Rd == ID_Rt)));
  assign tmr_inc  = tmr_q + TmrW'(1);

  // Counter events follow the same priority as the strobes, so each cycle
  // lands in at most one counter.
  assign live     = ~RST & (state_q != StErr);
  assign wait_ev  = live & memblk;
  assign flush_ev = live & ~memblk & EX_BrTaken;
  assign stall_ev = live & ~memblk & ~EX_BrTaken & load_use;

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StRun;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      StRun: begin
        if (memblk) begin
          state_d = StMemWait;
          tmr_d   = '0;
        end
      end
      StMemWait: begin
        if (DMemAck) begin
          state_d = StRun;
        end else if (tmr_inc == TmrW'(MEM_TIMEOUT)) begin
          state_d = StErr;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      StErr:   state_d = StErr;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    PCWr        = 1'b0;
    IFIDWr      = 1'b0;
    IDEXWr      = 1'b0;
    EXMEMWr     = 1'b0;
    MEMWBWr     = 1'b0;
    IFIDFlush   = 1'b0;
    IDEXFlush   = 1'b0;
    MEMWBBubble = 1'b0;
    Err         = 1'b0;
    if (RST) begin
      IFIDFlush   = 1'b1;
      IDEXFlush   = 1'b1;
      MEMWBBubble = 1'b1;
    end else if (state_q == StErr) begin
      Err = 1'b1;
    end else if (memblk) begin
      // Front of the pipe freezes; WB drains a bubble so nothing retires twice.
      MEMWBWr     = 1'b1;
      MEMWBBubble = 1'b1;
    end else if (EX_BrTaken) begin
      PCWr      = 1'b1;
      IFIDWr    = 1'b1;
      IDEXWr    = 1'b1;
      EXMEMWr   = 1'b1;
      MEMWBWr   = 1'b1;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (load_use) begin
      IDEXWr    = 1'b1;
      EXMEMWr   = 1'b1;
      MEMWBWr   = 1'b1;
      IDEXFlush = 1'b1;
    end else begin
      PCWr    = 1'b1;
      IFIDWr  = 1'b1;
      IDEXWr  = 1'b1;
      EXMEMWr = 1'b1;
      MEMWBWr = 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .inc_i (stall_ev),
    .cnt_o (StallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .inc_i (flush_ev),
    .cnt_o (FlushCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .inc_i (wait_ev),
    .cnt_o (WaitCnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized checks of pipe_hazard_ctrl against a cycle-level
// behavioural model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

  localparam int unsigned AW  = 5;
  localparam int unsigned CW  = 4;
  localparam int unsigned TO  = 4;
  localparam int          MAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] ID_Rs, ID_Rt, EX_Rd;
  logic          ID_UsesRt, EX_MemRd, EX_RegWr, EX_BrTaken, MEM_Req, DMemAck;
  logic          PCWr, IFIDWr, IDEXWr, EXMEMWr, MEMWBWr;
  logic          IFIDFlush, IDEXFlush, MEMWBBubble, Err;
  logic [CW-1:0] StallCnt, FlushCnt, WaitCnt;

  int checks = 0;
  int errors = 0;

  // Model state: whether we are waiting on memory, how many non-ack cycles
  // were spent waiting since entry, the sticky error, and raw event tallies.
  bit m_wait, m_err;
  int m_waited, m_stall, m_flush, m_waitn;

  pipe_hazard_ctrl #(
    .REG_AW      (AW),
    .CNT_W       (CW),
    .MEM_TIMEOUT (TO)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ID_Rs       (ID_Rs),
    .ID_Rt       (ID_Rt),
    .ID_UsesRt   (ID_UsesRt),
    .EX_Rd       (EX_Rd),
    .EX_MemRd    (EX_MemRd),
    .EX_RegWr    (EX_RegWr),
    .EX_BrTaken  (EX_BrTaken),
    .MEM_Req     (MEM_Req),
    .DMemAck     (DMemAck),
    .PCWr        (PCWr),
    .IFIDWr      (IFIDWr),
    .IDEXWr      (IDEXWr),
    .EXMEMWr     (EXMEMWr),
    .MEMWBWr     (MEMWBWr),
    .IFIDFlush   (IFIDFlush),
    .IDEXFlush   (IDEXFlush),
    .MEMWBBubble (MEMWBBubble),
    .Err         (Err),
    .StallCnt    (StallCnt),
    .FlushCnt    (FlushCnt),
    .WaitCnt     (WaitCnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int n);
    return (n > MAX) ? 32'(MAX) : 32'(n);
  endfunction

  // Strobe vector order: PCWr IFIDWr IDEXWr EXMEMWr MEMWBWr IFIDFlush IDEXFlush MEMWBBubble
  function automatic logic [7:0] strobes();
    return {PCWr, IFIDWr, IDEXWr, EXMEMWr, MEMWBWr, IFIDFlush, IDEXFlush, MEMWBBubble};
  endfunction

  function automatic logic [7:0] exp_strobes(input bit err, input bit blk, input bit br,
                                             input bit lu);
    if (err)      return 8'b00000_000;
    else if (blk) return 8'b00001_001;
    else if (br)  return 8'b11111_110;
    else if (lu)  return 8'b00111_010;
    else          return 8'b11111_000;
  endfunction

  task automatic check_counters();
    check("stall_cnt", 32'(StallCnt), sat(m_stall));
    check("flush_cnt", 32'(FlushCnt), sat(m_flush));
    check("wait_cnt",  32'(WaitCnt),  sat(m_waitn));
    check("err",       32'(Err),      32'(m_err));
  endtask

  // Entered at negedge+1; holds reset across one falling edge.
  task automatic do_reset();
    RST = 1'b1;
    #1;
    m_wait = 0; m_err = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_waitn = 0;
    check("rst_strobes", 32'(strobes()), 32'(8'b00000_111));
    check_counters();
    @(negedge CLK); #1;
    RST = 1'b0;
  endtask

  // One pipeline cycle: apply inputs, check comb strobes mid-cycle, advance model.
  task automatic step(input int rs, input int rt, input bit urt, input int rd,
                      input bit mrd, input bit rwr, input bit br, input bit req, input bit ack);
    bit blk, lu;
    ID_Rs = AW'(rs); ID_Rt = AW'(rt); ID_UsesRt = urt; EX_Rd = AW'(rd);
    EX_MemRd = mrd; EX_RegWr = rwr; EX_BrTaken = br; MEM_Req = req; DMemAck = ack;
    @(posedge CLK); #1;
    blk = req && !ack;
    lu  = mrd && rwr && (rd != 0) && ((rd == rs) || (urt && rd == rt));
    check("strobes", 32'(strobes()), 32'(exp_strobes(m_err, blk, br, lu)));
    check_counters();
    if (!m_err) begin
      if (blk)     m_waitn++;
      else if (br) m_flush++;
      else if (lu) m_stall++;
      if (m_wait) begin
        if (ack) m_wait = 0;
        else begin
          m_waited++;
          if (m_waited == TO) begin m_err = 1; m_wait = 0; end
        end
      end else if (blk) begin
        m_wait = 1; m_waited = 0;
      end
    end
    @(negedge CLK); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    RST = 1'b1;
    ID_Rs = '0; ID_Rt = '0; EX_Rd = '0; ID_UsesRt = 0; EX_MemRd = 0; EX_RegWr = 0;
    EX_BrTaken = 0; MEM_Req = 0; DMemAck = 0;
    #2;
    check("por_strobes", 32'(strobes()), 32'(8'b00000_111));
    check("por_err", 32'(Err), 32'd0);
    @(negedge CLK); #1;
    RST = 1'b0;

    // Load r3 in EX, ID reads r3 as rs: one bubble, then no re-trigger.
    step(3, 7, 0, 3, 1, 1, 0, 0, 0);
    step(3, 7, 0, 0, 0, 0, 0, 0, 0);
    check("lu_stall_cnt", 32'(StallCnt), 32'd1);
    step(0, 7, 0, 0, 1, 1, 0, 0, 0);       // EX_Rd = 0 never stalls
    step(5, 9, 1, 9, 1, 1, 0, 0, 0);       // hazard through rt
    step(5, 9, 0, 9, 1, 1, 0, 0, 0);       // rt not used: no hazard
    check("lu_rt_cnt", 32'(StallCnt), 32'd2);

    // Branch concurrent with load-use: branch wins.
    do_reset();
    step(3, 0, 0, 3, 1, 1, 1, 0, 0);
    idle();
    check("br_flush_cnt", 32'(FlushCnt), 32'd1);
    check("br_stall_cnt", 32'(StallCnt), 32'd0);

    // Ack delayed three cycles; zero-wait access in between.
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);       // branch ignored while blocked
    step(3, 0, 0, 3, 1, 1, 0, 1, 0);       // load-use ignored while blocked
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    check("wait3_cnt", 32'(WaitCnt), 32'd3);
    check("wait3_flush", 32'(FlushCnt), 32'd0);

    // Timeout: entry then TO non-ack cycles, then stuck in error.
    do_reset();
    for (int i = 0; i < TO + 1; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 1);
    check("timeout_err", 32'(Err), 32'd1);
    check("timeout_pcwr", 32'(PCWr), 32'd0);
    do_reset();
    check("timeout_cleared", 32'(Err), 32'd0);

    // Reset in the middle of a memory wait; late ack without request ignored.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);

    // Saturation of the flush counter.
    do_reset();
    for (int i = 0; i < MAX + 6; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("flush_sat", 32'(FlushCnt), 32'(MAX));

    // Randomized traffic with small register numbers so hazards are common.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0 || (m_err && $urandom_range(0, 3) == 0)) do_reset();
      step($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
